l1_fill_unit: RTL
=================

Name: l1_fill_unit

Overview:
- Miss-side partner of the L1 tag lookup.
- Accepts L1 miss requests and models the L2 or DRAM return latency per outstanding line.
- Produces the single-cycle tag-write pulse and line address that install the filled line in the L1 tag store.
- Sits between the coalescer/L1 lookup stage and the tag store; shares the pipeline stall with the lookup.

Parameters:
- ADDR_W, 32, byte address width (SIZE_ADDR).
- LINE_LOG, 7, log2 of memory line bytes (SIZE_MEMLINE_BYTES_LOG).
- NUM_ENTRIES, 4, outstanding-miss slots.
- ENTRY_LOG, 2, log2(NUM_ENTRIES).
- CNT_W, 10, latency counter width; must hold DRAM_DELAY.
- L2_DELAY, 20, fill latency in cycles on L2 hit.
- DRAM_DELAY, 400, fill latency in cycles on L2 miss.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; freezes all state.
- miss_valid  in  1  miss request present.
- miss_addr  in  ADDR_W  byte address of missing access.
- miss_l2_hit  in  1  selects L2_DELAY (1) or DRAM_DELAY (0).
- miss_ready  out  1  request accepted this cycle if miss_valid.
- tag_write  out  1  fill pulse to tag store write enable.
- tag_write_addr  out  ADDR_W  filled line address, low LINE_LOG bits zero.
- busy  out  1  any entry valid.
- outstanding  out  ENTRY_LOG+1  count of valid entries.

Behaviour:
- Reset: all entries invalid, counters 0; tag_write=0; tag_write_addr=0; busy=0; outstanding=0. miss_ready then equals ~stall.
- Entry state: valid, line address (miss_addr[ADDR_W-1:LINE_LOG]), counter[CNT_W].
- Handshake:
  - miss_ready = ~stall & (some entry invalid), computed from registered state only.
  - Accept when miss_valid & miss_ready.
  - Accept allocates the lowest-index invalid entry and loads counter = miss_l2_hit ? L2_DELAY : DRAM_DELAY.
- Countdown: each non-stall cycle, every valid entry with counter>0 decrements by 1; no wrap below 0.
- Completion:
  - A valid entry with counter==0 is done.
  - Lowest-index done entry wins (fixed priority).
  - On the same non-stall edge: tag_write<=1, tag_write_addr<={line,LINE_LOG'b0}, winning entry invalidated.
  - Losing done entries hold at 0 and compete next cycle, so there is one tag write per cycle maximum.
- No done entry on a non-stall edge: tag_write<=0.
- Latency: accept at edge t gives tag_write high after edge t+D+1, where D is the loaded delay.
- Stall: no accept, no decrement, no completion. tag_write and tag_write_addr hold their values; the tag store gates its write with ~stall, so the held pulse is consumed on the first non-stall edge.
- Simultaneous free and allocate: a slot freed on edge t is allocatable from edge t+1 (not same edge).
- Full: miss_ready=0; a request held on miss_valid waits, and the requester must keep miss_addr stable.
- Reset mid-operation: all in-flight fills discarded; no tag_write emitted.
- outstanding and busy are registered state, updated with allocate/free.

Optional Feature:
- Macro L1_MISS_MERGE_EN.
- Defined:
  - A miss whose line matches a valid entry is accepted without allocation; no second tag write.
  - miss_ready for a matching line is ~stall even when full.
  - A match against the entry completing on the same edge counts as a hit: accepted, no new allocation.
- Undefined:
  - Every accepted miss allocates.
  - Duplicate lines produce separate tag writes (harmless re-install).

Decomposition:
- Shared memory package holds:
  - ADDR width and line log.
  - L2_DELAY/DRAM_DELAY constants; replace the file-local L2Delay/DRAMDelay defines.
  - Entry record type (valid, line, counter).
- Natural sub-module: fill_prio_pick, a NUM_ENTRIES-wide lowest-index priority encoder. Used twice: free-slot allocation and done-entry selection.

Test Plan:
- Reset, then one miss with addr=0x0000_1234, l2_hit=1 at cycle 0 -> tag_write pulse exactly at cycle 21, tag_write_addr=0x0000_1200, outstanding 1->0.
- Four misses in consecutive cycles, l2_hit=0 -> miss_ready=0 for a fifth until the first pulse at cycle 401; four pulses on cycles 401-404 in order.
- Two misses accepted same delay, different lines, one cycle apart, with stall asserted 5 cycles mid-flight -> pulses shifted by exactly 5 cycles; tag_write held through any stall overlapping a pulse.
- Entry0 with DRAM delay, entry1 with L2 delay, entry1 done while entry0 running -> entry1 writes first; entry1 reallocatable the cycle after.
- Two entries reaching 0 on the same cycle -> lower index written first, other one cycle later.
- reset asserted at cycle 10 with 3 outstanding -> no tag_write ever; outstanding=0, miss_ready=1 next cycle.
- With L1_MISS_MERGE_EN, second miss to 0x1240 while 0x1200 line in flight -> accepted, outstanding stays 1, single tag_write. Without the macro -> outstanding 2, two tag_writes.

Source files
------------

// File: rtl/l1_fill_unit_pkg.sv
// Shared memory-side constants and the outstanding-miss entry record for the L1 fill unit.
package l1_fill_unit_pkg;

    localparam int ADDR_W      = 32;
    localparam int LINE_LOG    = 7;
    localparam int LINE_W      = ADDR_W - LINE_LOG;
    localparam int NUM_ENTRIES = 4;
    localparam int ENTRY_LOG   = 2;
    localparam int CNT_W       = 10;

    localparam logic [CNT_W-1:0] L2_DELAY   = CNT_W'(20);
    localparam logic [CNT_W-1:0] DRAM_DELAY = CNT_W'(400);

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] line;
        logic [CNT_W-1:0]  cnt;
    } fill_entry_t;

    function automatic logic [CNT_W-1:0] fill_delay(input logic l2_hit);
        return l2_hit ? L2_DELAY : DRAM_DELAY;
    endfunction

endpackage

// File: rtl/l1_fill_unit_prio_pick.sv
// Lowest-index-wins priority encoder; used for free-slot allocation and done-entry selection.
module fill_prio_pick #(
    parameter int N   = 4,
    parameter int LOG = 2
) (
    input  logic [N-1:0]   req,
    output logic           found,
    output logic [LOG-1:0] idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = LOG'(i);
            end
        end
    end

endmodule

// File: rtl/l1_fill_unit.sv
// L1 miss fill unit: tracks outstanding misses, models L2/DRAM latency, emits one tag write per cycle.
// Optional miss merging into an in-flight line is enabled by defining L1_MISS_MERGE_EN.
module l1_fill_unit
    import l1_fill_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 miss_valid,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic                 miss_l2_hit,
    output logic                 miss_ready,
    output logic                 tag_write,
    output logic [ADDR_W-1:0]    tag_write_addr,
    output logic                 busy,
    output logic [ENTRY_LOG:0]   outstanding
);

    fill_entry_t              entries [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   free_vec;
    logic [NUM_ENTRIES-1:0]   done_vec;
    logic                     free_found;
    logic                     done_found;
    logic [ENTRY_LOG-1:0]     free_idx;
    logic [ENTRY_LOG-1:0]     done_idx;
    logic [LINE_W-1:0]        miss_line;
    logic                     merge_hit;
    logic                     do_alloc;
    logic [ENTRY_LOG:0]       outstanding_nxt;
    logic                     unused_offset_bits;

    assign miss_line          = miss_addr[ADDR_W-1:LINE_LOG];
    assign unused_offset_bits = ^miss_addr[LINE_LOG-1:0];

    always_comb begin
        free_vec = '0;
        done_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i] = ~entries[i].valid;
            done_vec[i] = entries[i].valid && (entries[i].cnt == '0);
        end
    end

    fill_prio_pick #(.N(NUM_ENTRIES), .LOG(ENTRY_LOG)) u_free_pick (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    fill_prio_pick #(.N(NUM_ENTRIES), .LOG(ENTRY_LOG)) u_done_pick (
        .req   (done_vec),
        .found (done_found),
        .idx   (done_idx)
    );

`ifdef L1_MISS_MERGE_EN
    logic [NUM_ENTRIES-1:0] match_vec;

    // An entry completing this edge still matches: the request rides on that fill.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_vec[i] = entries[i].valid && (entries[i].line == miss_line);
        end
    end

    assign merge_hit = |match_vec;
`else
    assign merge_hit = 1'b0;
`endif

    // Ready depends only on registered entry state, never on this cycle's completion.
    assign miss_ready      = ~stall & (free_found | merge_hit);
    assign do_alloc        = miss_valid & miss_ready & ~merge_hit;
    assign outstanding_nxt = outstanding + (ENTRY_LOG+1)'(do_alloc) - (ENTRY_LOG+1)'(done_found);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the entry array is small and its valid bits gate everything, so it is fully reset.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            tag_write      <= 1'b0;
            tag_write_addr <= '0;
            outstanding    <= '0;
            busy           <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking updates so every entry sees the same pre-edge state.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (done_found && (done_idx == ENTRY_LOG'(i))) begin
                    entries[i].valid <= 1'b0;
                end else if (do_alloc && (free_idx == ENTRY_LOG'(i))) begin
                    entries[i].valid <= 1'b1;
                    entries[i].line  <= miss_line;
                    entries[i].cnt   <= fill_delay(miss_l2_hit);
                end else if (entries[i].valid && (entries[i].cnt != '0)) begin
                    entries[i].cnt <= entries[i].cnt - CNT_W'(1);
                end
            end
            tag_write <= done_found;
            if (done_found) begin
                tag_write_addr <= {entries[done_idx].line, {LINE_LOG{1'b0}}};
            end
            outstanding <= outstanding_nxt;
            busy        <= (outstanding_nxt != '0);
        end
    end

endmodule
